// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
// Shared types and helpers for the 4x4 keypad scanner:
//   - debounce FSM state encoding
//   - frame result encoding (NONE / KEY / MULTI)
//   - row drive patterns and small bit helpers used by the scanner
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_e;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_e;

  // Active-low row drive, row_index 0..3.
  localparam logic [3:0] ROW0_N = 4'b1110;
  localparam logic [3:0] ROW1_N = 4'b1101;
  localparam logic [3:0] ROW2_N = 4'b1011;
  localparam logic [3:0] ROW3_N = 4'b0111;

  function automatic logic [3:0] row_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = ROW0_N;
      2'd1:    pat = ROW1_N;
      2'd2:    pat = ROW2_N;
      default: pat = ROW3_N;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] ones_index4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Frame-level debouncer. Consumes one resolved frame per frame_valid_i strobe
// and accepts a press or release after DEB_FRAMES identical frames.
// MULTI frames are treated exactly like NONE (ghost rejection).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   frame_valid_i       one-cycle strobe on the frame-end cycle
//   frame_res_i         NONE / KEY / MULTI for that frame
//   frame_code_i        key code when frame_res_i is KEY
//   key_o               last accepted key code
//   pressed_o           high in HELD and RELEASE_WAIT
//   key_pulse_o         one-cycle strobe on each accepted press
//
// state         | meaning
// RELEASED      | no key accepted, waiting for a first KEY frame
// PRESS_WAIT    | counting consecutive frames of the candidate code
// HELD          | key accepted and still present
// RELEASE_WAIT  | counting consecutive empty frames before release
module keypad_debounce
  import keypad_scan_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_valid_i,
  input  frame_res_e frame_res_i,
  input  logic [3:0] frame_code_i,
  output logic [3:0] key_o,
  output logic       pressed_o,
  output logic       key_pulse_o
);

  localparam logic [3:0] DEB_TGT = 4'(DEB_FRAMES);

  deb_state_e state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_q, key_d;
  logic       pulse_q, pulse_d;
  logic       is_key;
  logic [3:0] count_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RELEASED;
      count_q <= 4'd0;
      cand_q  <= 4'd0;
      key_q   <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cand_d    = cand_q;
    key_d     = key_q;
    pulse_d   = 1'b0;
    is_key    = (frame_res_i == FR_KEY);
    count_inc = count_q + 4'd1;
    if (frame_valid_i) begin
      case (state_q)
        ST_RELEASED: begin
          if (is_key) begin
            state_d = ST_PRESS_WAIT;
            cand_d  = frame_code_i;
            count_d = 4'd1;
          end
        end
        ST_PRESS_WAIT: begin
          if (is_key && frame_code_i == cand_q) begin
            if (count_inc == DEB_TGT) begin
              state_d = ST_HELD;
              key_d   = cand_q;
              pulse_d = 1'b1;
              count_d = 4'd0;
            end else begin
              count_d = count_inc;
            end
          end else if (is_key) begin
            cand_d  = frame_code_i;
            count_d = 4'd1;
          end else begin
            state_d = ST_RELEASED;
            count_d = 4'd0;
          end
        end
        ST_HELD: begin
          // No rollover: any key code keeps the current acceptance.
          if (!is_key) begin
            state_d = ST_RELEASE_WAIT;
            count_d = 4'd1;
          end
        end
        default: begin
          if (is_key) begin
            state_d = ST_HELD;
            count_d = 4'd0;
          end else if (count_inc == DEB_TGT) begin
            state_d = ST_RELEASED;
            count_d = 4'd0;
          end else begin
            count_d = count_inc;
          end
        end
      endcase
    end
  end

  assign key_o       = key_q;
  assign key_pulse_o = pulse_q;
  assign pressed_o   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner: drives one row low per dwell of SCAN_DIV
// cycles, samples the synchronized columns on the last dwell cycle,
// resolves each 4-row frame to NONE / KEY / MULTI and hands it to the
// debouncer.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   col_n[3:0] keypad columns, active-low, asynchronous
//   row_n[3:0] row drive, exactly one bit low
//   key[3:0]   last accepted key, row_index*4+col_index
//   pressed    high while an accepted key is held
//   key_pulse  one-cycle strobe per accepted press
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 20000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       pressed,
  output logic       key_pulse
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       col_meta_q, col_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic             found_q, found_d;
  logic             multi_q, multi_d;
  logic [3:0]       code_q, code_d;

  logic             tc;
  logic [3:0]       col_low;
  logic [2:0]       n_low;
  logic             frame_end;
  frame_res_e       frame_res;
  logic [3:0]       frame_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      cnt_q      <= '0;
      row_idx_q  <= 2'd0;
      row_q      <= ROW0_N;
      found_q    <= 1'b0;
      multi_q    <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      row_q      <= row_d;
      found_q    <= found_d;
      multi_q    <= multi_d;
      code_q     <= code_d;
    end
  end

  always_comb begin
    tc         = (cnt_q == CNT_TC);
    col_low    = ~col_sync_q;
    n_low      = count_ones4(col_low);
    cnt_d      = tc ? '0 : cnt_q + 1'b1;
    row_idx_d  = tc ? row_idx_q + 2'd1 : row_idx_q;
    row_d      = tc ? row_pattern(row_idx_q + 2'd1) : row_q;
    found_d    = found_q;
    multi_d    = multi_q;
    code_d     = code_q;
    if (tc) begin
      if (n_low == 3'd1) begin
        // A second row with a single low also makes the frame ambiguous.
        if (found_q) multi_d = 1'b1;
        else begin
          found_d = 1'b1;
          code_d  = {row_idx_q, ones_index4(col_low)};
        end
      end else if (n_low > 3'd1) begin
        multi_d = 1'b1;
      end
    end
    // The row-3 sample is folded in combinationally so the debouncer sees
    // the complete frame on the frame-end cycle itself.
    frame_end  = tc && (row_idx_q == 2'd3);
    frame_res  = multi_d ? FR_MULTI : (found_d ? FR_KEY : FR_NONE);
    frame_code = code_d;
    if (frame_end) begin
      found_d = 1'b0;
      multi_d = 1'b0;
      code_d  = 4'd0;
    end
  end

  keypad_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_debounce (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_valid_i(frame_end),
    .frame_res_i  (frame_res),
    .frame_code_i (frame_code),
    .key_o        (key),
    .pressed_o    (pressed),
    .key_pulse_o  (key_pulse)
  );

  assign row_n = row_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=8, DEB_FRAMES=3 (one frame = 32 cycles).
// A keypad matrix model turns the set of held keys into col_n from row_n.
// Expected key codes are queued when a press should complete and popped
// whenever key_pulse is seen.
module tb_keypad_scan;

  localparam int SCAN_DIV   = 8;
  localparam int DEB_FRAMES = 3;

  logic       clk;
  logic       rst;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       pressed;
  logic       key_pulse;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          checks;
  int          failures;
  int          pulse_cnt;
  logic        prev_pulse;

  keypad_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_FRAMES(DEB_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key),
    .pressed  (pressed),
    .key_pulse(key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_n[c] = 1'b0;
  end

  // Advance one clock, sample #1 after the edge, and score key_pulse.
  task automatic step_cycle();
    logic [3:0] exp_key;
    @(posedge clk);
    #1;
    checks++;
    if ($countones(~row_n) != 1) begin
      failures++;
      $display("FAIL row_onehot: row_n=%b, required exactly one low bit", row_n);
    end
    if (key_pulse) begin
      pulse_cnt++;
      checks++;
      if (prev_pulse) begin
        failures++;
        $display("FAIL pulse_width: key_pulse high two cycles, required one");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: key_pulse with key=%0d, required no pulse", key);
      end else begin
        exp_key = exp_q.pop_front();
        if (key !== exp_key) begin
          failures++;
          $display("FAIL pulse_key: key=%0d, required %0d", key, exp_key);
        end
      end
    end
    prev_pulse = key_pulse;
  endtask

  // Return on the cycle a new frame starts (row_n 0111 -> 1110).
  task automatic wait_frame();
    logic [3:0] prev;
    prev = row_n;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (row_n == 4'b1110 && prev == 4'b0111) return;
      prev = row_n;
    end
    checks++;
    failures++;
    $display("FAIL frame_timeout: no frame boundary within 40 cycles");
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) wait_frame();
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1110;
    exp_rows[1] = 4'b1101;
    exp_rows[2] = 4'b1011;
    exp_rows[3] = 4'b0111;
    rst  = 1'b1;
    keys = 16'h0000;
    repeat (3) step_cycle();
    checks++;
    if (row_n !== 4'b1110 || key !== 4'd0 || pressed !== 1'b0 || key_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: row_n=%b key=%0d pressed=%b pulse=%b, required 1110 0 0 0",
               row_n, key, pressed, key_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) step_cycle();
      checks++;
      if (row_n !== exp_rows[i]) begin
        failures++;
        $display("FAIL row_seq%0d: row_n=%b, required %b", i, row_n, exp_rows[i]);
      end
      repeat (4) step_cycle();
    end
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulse_cnt;
    keys = 16'h0000;
    keys[9] = 1'b1;
    wait_frames(2);
    checks++;
    if (pulse_cnt != p0 || pressed !== 1'b0) begin
      failures++;
      $display("FAIL early_accept: pulses=%0d pressed=%b, required 0 0", pulse_cnt - p0, pressed);
    end
    exp_q.push_back(4'd9);
    wait_frame();
    repeat (3) step_cycle();
    checks++;
    if (pulse_cnt != p0 + 1 || key !== 4'd9 || pressed !== 1'b1) begin
      failures++;
      $display("FAIL press9: pulses=%0d key=%0d pressed=%b, required 1 9 1",
               pulse_cnt - p0, key, pressed);
    end
    keys = 16'h0000;
    wait_frames(3);
    checks++;
    if (pressed !== 1'b0 || key !== 4'd9) begin
      failures++;
      $display("FAIL release9: pressed=%b key=%0d, required 0 9", pressed, key);
    end
  endtask

  task automatic test_bounce();
    int p0;
    wait_frame();
    p0 = pulse_cnt;
    keys = 16'h0000; keys[9] = 1'b1;
    wait_frames(2);
    keys = 16'h0000;
    wait_frame();
    keys[9] = 1'b1;
    wait_frames(2);
    checks++;
    if (pulse_cnt != p0 || pressed !== 1'b0) begin
      failures++;
      $display("FAIL bounce_early: pulses=%0d pressed=%b, required 0 0", pulse_cnt - p0, pressed);
    end
    exp_q.push_back(4'd9);
    wait_frame();
    repeat (2) step_cycle();
    checks++;
    if (pulse_cnt != p0 + 1 || pressed !== 1'b1) begin
      failures++;
      $display("FAIL bounce_accept: pulses=%0d pressed=%b, required 1 1", pulse_cnt - p0, pressed);
    end
    keys = 16'h0000;
    wait_frames(3);
  endtask

  task automatic test_multi();
    int p0;
    p0 = pulse_cnt;
    keys = 16'h0000; keys[0] = 1'b1; keys[5] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_frame();
      checks++;
      if (pressed !== 1'b0) begin
        failures++;
        $display("FAIL multi_pressed%0d: pressed=%b, required 0", f, pressed);
      end
    end
    checks++;
    if (pulse_cnt != p0 || key !== 4'd9) begin
      failures++;
      $display("FAIL multi_reject: pulses=%0d key=%0d, required 0 9", pulse_cnt - p0, key);
    end
    keys = 16'h0000;
    wait_frame();
  endtask

  task automatic test_release_glitch();
    int p0;
    p0 = pulse_cnt;
    keys = 16'h0000; keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_frames(3);
    keys = 16'h0000;
    for (int f = 0; f < 2; f++) begin
      wait_frame();
      checks++;
      if (pressed !== 1'b1) begin
        failures++;
        $display("FAIL glitch_rel%0d: pressed=%b, required 1", f, pressed);
      end
    end
    keys[9] = 1'b1;
    wait_frame();
    checks++;
    if (pressed !== 1'b1) begin
      failures++;
      $display("FAIL glitch_repress: pressed=%b, required 1", pressed);
    end
    keys = 16'h0000;
    wait_frames(2);
    checks++;
    if (pressed !== 1'b1) begin
      failures++;
      $display("FAIL glitch_relwait: pressed=%b, required 1", pressed);
    end
    wait_frame();
    checks++;
    if (pressed !== 1'b0 || key !== 4'd9 || pulse_cnt != p0 + 1) begin
      failures++;
      $display("FAIL glitch_final: pressed=%b key=%0d pulses=%0d, required 0 9 1",
               pressed, key, pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int p0;
    p0 = pulse_cnt;
    keys = 16'h0000; keys[9] = 1'b1;
    wait_frames(2);
    repeat (10) step_cycle();
    rst = 1'b1;
    step_cycle();
    checks++;
    if (row_n !== 4'b1110 || key !== 4'd0 || pressed !== 1'b0 || key_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: row_n=%b key=%0d pressed=%b pulse=%b, required 1110 0 0 0",
               row_n, key, pressed, key_pulse);
    end
    rst = 1'b0;
    wait_frames(2);
    checks++;
    if (pulse_cnt != p0 || pressed !== 1'b0) begin
      failures++;
      $display("FAIL midreset_early: pulses=%0d pressed=%b, required 0 0", pulse_cnt - p0, pressed);
    end
    exp_q.push_back(4'd9);
    wait_frame();
    step_cycle();
    checks++;
    if (pulse_cnt != p0 + 1 || key !== 4'd9 || pressed !== 1'b1) begin
      failures++;
      $display("FAIL midreset_accept: pulses=%0d key=%0d pressed=%b, required 1 9 1",
               pulse_cnt - p0, key, pressed);
    end
    keys = 16'h0000;
    wait_frames(4);
  endtask

  task automatic test_key15_wrap();
    int p0;
    p0 = pulse_cnt;
    keys = 16'h0000; keys[15] = 1'b1;
    exp_q.push_back(4'd15);
    wait_frames(4);
    checks++;
    if (pulse_cnt != p0 + 1 || key !== 4'd15 || pressed !== 1'b1) begin
      failures++;
      $display("FAIL key15: pulses=%0d key=%0d pressed=%b, required 1 15 1",
               pulse_cnt - p0, key, pressed);
    end
    keys = 16'h0000;
    wait_frames(3);
    checks++;
    if (pressed !== 1'b0 || key !== 4'd15) begin
      failures++;
      $display("FAIL key15_release: pressed=%b key=%0d, required 0 15", pressed, key);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    pulse_cnt  = 0;
    prev_pulse = 1'b0;
    rst        = 1'b1;
    keys       = 16'h0000;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_release_glitch();
    test_reset_mid_debounce();
    test_key15_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 20000, clk cycles each row is driven low (dwell); legal range 8..2^20.
REQ-002 Parameter DEB_FRAMES, default 4, consecutive identical frames needed to accept a press or a release; legal range 2..15.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 col_n  input  4  keypad column lines, active-low, asynchronous to clk.
REQ-006 row_n  output  4  keypad row drive, exactly one bit low at any time.
REQ-007 key  output  4  code of the last accepted key, row_index*4+col_index.
REQ-008 pressed  output  1  high while an accepted key is held.
REQ-009 key_pulse  output  1  one-cycle strobe on each accepted new press.

Function
REQ-010 col_n SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Row drive SHALL cycle 1110, 1101, 1011, 0111, then wrap to 1110; row_index 0..3 in that order.
REQ-012 Dwell counter SHALL count 0..SCAN_DIV-1; on terminal count row_n advances on the next edge and the counter wraps to 0.
REQ-013 Columns SHALL be sampled on the terminal-count cycle of each dwell only (synchronized value).
REQ-014 col_index SHALL be the position of the single low bit of the sample (bit 0 = col 0).
REQ-015 A frame (4 dwells, rows 0..3) SHALL resolve to NONE, KEY(code) or MULTI.
REQ-016 Frame resolves to KEY only if exactly one row sample across the frame has exactly one low bit; zero lows everywhere = NONE; anything else = MULTI.
REQ-017 MULTI frames SHALL be treated as NONE by the debouncer (ghost rejection).
REQ-018 Debounce FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-019 RELEASED: KEY(c) frame -> PRESS_WAIT, candidate=c, match count=1; NONE stays.
REQ-020 PRESS_WAIT: KEY(candidate) increments count; on reaching DEB_FRAMES -> HELD, key<=candidate, key_pulse for one cycle; KEY(other) restarts with new candidate, count=1; NONE -> RELEASED.
REQ-021 HELD: NONE frame -> RELEASE_WAIT, count=1; KEY(any code) stays HELD (no rollover, no new pulse).
REQ-022 RELEASE_WAIT: NONE increments; at DEB_FRAMES -> RELEASED; any KEY frame -> HELD, count cleared.
REQ-023 pressed SHALL be high in HELD and RELEASE_WAIT, low otherwise.
REQ-024 key_pulse SHALL assert in the clk cycle after the frame-end cycle that completes the debounce; never two consecutive cycles.
REQ-025 key SHALL hold its value after release until the next accepted press.
REQ-026 Minimum press latency = DEB_FRAMES*4*SCAN_DIV cycles from first full qualifying frame start, +1 cycle for key_pulse.

Reset
REQ-027 While rst high at a clk edge: row_n=1110, dwell counter=0, row_index=0, frame accumulator cleared, FSM=RELEASED, count=0, key=0, pressed=0, key_pulse=0, synchronizer flops=1111.
REQ-028 Reset mid-frame or mid-debounce SHALL discard partial results; scanning restarts at row 0 on the first cycle after rst falls.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, frame-result encoding (NONE/KEY/MULTI) and the row drive pattern constants.
REQ-030 The debounce FSM SHALL be a sub-module keypad_debounce fed by a frame-valid strobe and frame result; scanner and synchronizer stay in keypad_scan.

Verification (SCAN_DIV=8, DEB_FRAMES=3)
REQ-031 Hold row 2/col 1 (code 9) steady -> key_pulse exactly once, key=9, pressed=1 after 3 qualifying frames (96 cycles + sync/alignment), row_n sequence observed 1110,1101,1011,0111.
REQ-032 Key 9 bounces (present 2 frames, absent 1, present 3) -> single key_pulse only after the final 3-frame run.
REQ-033 Keys 0 and 5 held together -> MULTI every frame, no key_pulse, pressed stays 0, key unchanged.
REQ-034 Key 9 accepted, then released for 2 frames, re-pressed -> pressed never drops, no second key_pulse; then released 3 frames -> pressed=0, key still 9.
REQ-035 Assert rst during PRESS_WAIT with count=2 -> all outputs at reset values next cycle, row_n=1110; key held afterwards needs full 3 frames again.
REQ-036 Key 15 (row 3/col 3) held across row wrap -> key=15, key_pulse once.
